round_key_store: RTL and testbench

- Round-key buffer directly downstream of the round_key key-expansion block.
- Captures each round key written by the expander (w_e / round_key_addr / round_key) into a 15-entry array.
- Tracks which entries have been filled and declares the key schedule ready on the expander's done pulse.
- Serves registered, 1-cycle-latency reads to the cipher round datapath.

---
 rtl/aes_pkg.sv | 20 ++
 rtl/round_key_ram.sv | 27 ++
 rtl/round_key_store.sv | 119 +++++++++++
 tb/tb_round_key_store.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES key-schedule types and constants
package aes_pkg;

  typedef enum logic [1:0] {EMPTY, LOADING, READY, ERROR} key_store_state_t;

  localparam int NR_128          = 10;
  localparam int NR_256          = 14;
  localparam int KEY_STORE_DEPTH = 15;

  // Entries 0..rounds_total that must be filled for a complete schedule.
  function automatic logic [KEY_STORE_DEPTH-1:0] fill_need(input int rounds);
    logic [KEY_STORE_DEPTH-1:0] m;
    m = '0;
    for (int i = 0; i < KEY_STORE_DEPTH; i++) begin
      if (i <= rounds) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/round_key_ram.sv
// rtl/round_key_ram.sv - simple dual-port round-key array, registered read port
module round_key_ram #(
  parameter int WIDTH  = 128,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 15
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register only advances on accepted reads so rejected reads hold data.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/round_key_store.sv
// rtl/round_key_store.sv - captures expander round keys, tracks fill, serves reads
module round_key_store
  import aes_pkg::*;
#(
  parameter int ROUND_KEY_BITS = 128,
  parameter int ADDR_W         = 4,
  parameter int DEPTH          = KEY_STORE_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      key_load,
  input  logic [ADDR_W-1:0]         rounds_total,
  input  logic                      w_e,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [ROUND_KEY_BITS-1:0] wr_key,
  input  logic                      exp_done,
  input  logic                      rd_en,
  input  logic [ADDR_W-1:0]         rd_addr,
  output logic [ROUND_KEY_BITS-1:0] rd_data,
  output logic                      rd_valid,
  output logic                      rd_err,
  output logic                      keys_ready,
  output logic                      key_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  key_store_state_t state, state_nxt;

  logic [ADDR_W-1:0]         rt_q;
  logic [DEPTH-1:0]          mask_q;
  logic [DEPTH-1:0]          mask_wr;
  logic [DEPTH-1:0]          need;
  logic                      load_wr;
  logic                      wr_ok;
  logic                      wr_bad;
  logic                      complete;
  logic                      rd_ok;
  logic                      rd_acc;
  logic                      rd_seen;
  logic [ROUND_KEY_BITS-1:0] ram_rdata;

  // key_load has priority over any write in the same cycle.
  assign load_wr = (state == LOADING) && w_e && !key_load;
  assign wr_ok   = load_wr && (wr_addr <= rt_q) && (wr_addr <= LAST_ADDR);
  assign wr_bad  = load_wr && !wr_ok;

  // Completeness includes a write landing in the same cycle as exp_done.
  assign mask_wr  = mask_q | (wr_ok ? (DEPTH'(1) << wr_addr) : '0);
  assign need     = fill_need(int'(rt_q));
  assign complete = ((mask_wr & need) == need) && (rt_q <= LAST_ADDR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (key_load) begin
      state_nxt = LOADING;
    end else if (state == LOADING) begin
      if (wr_bad)        state_nxt = ERROR;
      else if (exp_done) state_nxt = complete ? READY : ERROR;
    end
  end

  always_comb begin
    keys_ready = (state == READY);
    key_err    = (state == ERROR);
    rd_data    = rd_seen ? ram_rdata : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rt_q   <= '0;
      mask_q <= '0;
    end else if (key_load) begin
      rt_q   <= rounds_total;
      mask_q <= '0;
    end else if (wr_ok) begin
      mask_q <= mask_wr;
    end
  end

  // Reads see the pre-load state, so a read alongside key_load returns old data.
  assign rd_ok  = (state == READY) && (rd_addr <= rt_q) && (rd_addr <= LAST_ADDR);
  assign rd_acc = rd_en && rd_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_seen  <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      rd_err   <= rd_en && !rd_ok;
      if (rd_acc) rd_seen <= 1'b1;
    end
  end

  round_key_ram #(
    .WIDTH  (ROUND_KEY_BITS),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_addr),
    .wdata (wr_key),
    .re    (rd_acc),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_round_key_store.sv
// tb/tb_round_key_store.sv - scoreboard bench for round_key_store
module tb_round_key_store;

  logic         clk = 1'b0;
  logic         reset;
  logic         key_load;
  logic [3:0]   rounds_total;
  logic         w_e;
  logic [3:0]   wr_addr;
  logic [127:0] wr_key;
  logic         exp_done;
  logic         rd_en;
  logic [3:0]   rd_addr;
  logic [127:0] rd_data;
  logic         rd_valid;
  logic         rd_err;
  logic         keys_ready;
  logic         key_err;

  typedef struct {
    logic         err;
    logic [127:0] data;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  exp_t         end_e;
  int           vectors     = 0;
  int           miscompares = 0;
  logic [127:0] model_last;

  always #5 clk = ~clk;

  round_key_store dut (
    .clk          (clk),
    .reset        (reset),
    .key_load     (key_load),
    .rounds_total (rounds_total),
    .w_e          (w_e),
    .wr_addr      (wr_addr),
    .wr_key       (wr_key),
    .exp_done     (exp_done),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_err       (rd_err),
    .keys_ready   (keys_ready),
    .key_err      (key_err)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Known FIPS-197 round keys in storage byte order; other entries get a tag pattern.
  function automatic logic [127:0] key_for(input logic m256, input logic [3:0] a);
    logic [7:0] b;
    if (a == 4'd0) return 128'h0f0e0d0c0b0a09080706050403020100;
    if (!m256 && a == 4'd10) return 128'hc5302b4d8ba707f3174a94e37f1d1113;
    if (m256 && a == 4'd1) return 128'h1f1e1d1c1b1a19181716151413121110;
    if (m256 && a == 4'd14) return 128'h36de686d3cc21a37e97909bfcc79fc24;
    b = {3'b000, m256, a};
    return {16{b}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic ok, input logic [127:0] d);
    exp_t e;
    if (ok) begin
      e.err = 1'b0;
      e.data = d;
      model_last = d;
    end else begin
      e.err = 1'b1;
      e.data = model_last;
    end
    sb.push_back(e);
  endtask

  task automatic do_load(input logic [3:0] rt);
    key_load = 1'b1;
    rounds_total = rt;
    tick();
    key_load = 1'b0;
  endtask

  task automatic do_wr(input logic [3:0] a, input logic [127:0] d);
    w_e = 1'b1;
    wr_addr = a;
    wr_key = d;
    tick();
    w_e = 1'b0;
  endtask

  task automatic do_rd(input logic [3:0] a, input logic ok, input logic [127:0] d);
    rd_en = 1'b1;
    rd_addr = a;
    push_exp(ok, d);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic pulse_done();
    exp_done = 1'b1;
    tick();
    exp_done = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset && (rd_valid || rd_err)) begin
      check("rd_exclusive", 128'(rd_valid & rd_err), 128'd0);
      if (sb.size() == 0) begin
        check("rd_unexpected", 128'({rd_valid, rd_err}), 128'd0);
      end else begin
        mon_e = sb.pop_front();
        check("rd_err_flag", 128'(rd_err), 128'(mon_e.err));
        check("rd_valid_flag", 128'(rd_valid), 128'(!mon_e.err));
        check("rd_data", rd_data, mon_e.data);
      end
    end
  end

  initial begin
    reset = 1'b0;
    key_load = 1'b0;
    rounds_total = 4'd0;
    w_e = 1'b0;
    wr_addr = 4'd0;
    wr_key = '0;
    exp_done = 1'b0;
    rd_en = 1'b0;
    rd_addr = 4'd0;
    model_last = '0;

    @(negedge clk);
    check("reset_rd_data", rd_data, 128'd0);
    check("reset_keys_ready", 128'(keys_ready), 128'd0);
    check("reset_key_err", 128'(key_err), 128'd0);
    check("reset_rd_valid", 128'(rd_valid), 128'd0);
    check("reset_rd_err", 128'(rd_err), 128'd0);
    tick();
    reset = 1'b1;
    tick();

    // AES-128 load and reads
    do_load(4'd10);
    for (int a = 0; a <= 10; a++) do_wr(4'(a), key_for(1'b0, 4'(a)));
    exp_done = 1'b1;
    @(negedge clk);
    check("k128_ready_before", 128'(keys_ready), 128'd0);
    tick();
    exp_done = 1'b0;
    @(negedge clk);
    check("k128_ready_after", 128'(keys_ready), 128'd1);
    do_rd(4'd0, 1'b1, key_for(1'b0, 4'd0));
    do_rd(4'd10, 1'b1, key_for(1'b0, 4'd10));

    // writes outside LOADING are ignored
    do_wr(4'd0, {128{1'b1}});
    do_rd(4'd0, 1'b1, key_for(1'b0, 4'd0));

    // range check and back-to-back throughput
    do_rd(4'd11, 1'b0, '0);
    rd_en = 1'b1;
    for (int a = 0; a <= 10; a++) begin
      rd_addr = 4'(a);
      push_exp(1'b1, key_for(1'b0, 4'(a)));
      tick();
    end
    rd_en = 1'b0;

    // AES-256 reload from READY with a read alongside key_load
    rd_en = 1'b1;
    rd_addr = 4'd0;
    key_load = 1'b1;
    rounds_total = 4'd14;
    push_exp(1'b1, key_for(1'b0, 4'd0));
    tick();
    rd_en = 1'b0;
    key_load = 1'b0;
    @(negedge clk);
    check("k256_ready_drop", 128'(keys_ready), 128'd0);
    for (int a = 0; a <= 13; a++) do_wr(4'(a), key_for(1'b1, 4'(a)));
    w_e = 1'b1;
    wr_addr = 4'd14;
    wr_key = key_for(1'b1, 4'd14);
    exp_done = 1'b1;
    tick();
    w_e = 1'b0;
    exp_done = 1'b0;
    @(negedge clk);
    check("k256_ready", 128'(keys_ready), 128'd1);
    check("k256_key_err", 128'(key_err), 128'd0);
    do_rd(4'd14, 1'b1, key_for(1'b1, 4'd14));
    do_rd(4'd1, 1'b1, key_for(1'b1, 4'd1));
    do_rd(4'd15, 1'b0, '0);

    // incomplete schedule; the write alongside key_load is dropped
    key_load = 1'b1;
    rounds_total = 4'd10;
    w_e = 1'b1;
    wr_addr = 4'd10;
    wr_key = key_for(1'b0, 4'd10);
    tick();
    key_load = 1'b0;
    w_e = 1'b0;
    for (int a = 0; a <= 9; a++) do_wr(4'(a), key_for(1'b0, 4'(a)));
    pulse_done();
    @(negedge clk);
    check("incomplete_key_err", 128'(key_err), 128'd1);
    check("incomplete_ready", 128'(keys_ready), 128'd0);
    do_rd(4'd0, 1'b0, '0);

    // illegal write address
    do_load(4'd10);
    @(negedge clk);
    check("load_clears_err", 128'(key_err), 128'd0);
    do_wr(4'd12, key_for(1'b0, 4'd12));
    @(negedge clk);
    check("illegal_wr_err", 128'(key_err), 128'd1);
    do_load(4'd10);
    @(negedge clk);
    check("reload_clears_err", 128'(key_err), 128'd0);

    // asynchronous reset mid-LOADING
    for (int a = 0; a <= 4; a++) do_wr(4'(a), key_for(1'b0, 4'(a)));
    #2;
    reset = 1'b0;
    #1;
    check("async_rd_data", rd_data, 128'd0);
    check("async_keys_ready", 128'(keys_ready), 128'd0);
    check("async_key_err", 128'(key_err), 128'd0);
    check("async_rd_valid", 128'(rd_valid), 128'd0);
    check("async_rd_err", 128'(rd_err), 128'd0);
    model_last = '0;
    tick();
    reset = 1'b1;
    pulse_done();
    @(negedge clk);
    check("post_reset_ready", 128'(keys_ready), 128'd0);
    check("post_reset_key_err", 128'(key_err), 128'd0);
    do_rd(4'd0, 1'b0, '0);

    repeat (3) tick();
    while (sb.size() > 0) begin
      end_e = sb.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL rd_missing: got no response expected err=%0d data=%h", end_e.err, end_e.data);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
